// File: rtl/cnn_pkg.sv
// Shared dimensions, widths and FSM encoding for the streaming digit classifier.
package cnn_pkg;
  localparam int unsigned IMG    = 28;
  localparam int unsigned K      = 5;
  localparam int unsigned CONV   = 24;
  localparam int unsigned POOL   = 12;
  localparam int unsigned NFEAT  = 144;
  localparam int unsigned NCLASS = 10;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned W_W    = 8;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned B_W    = 16;
  localparam int unsigned SUM_W  = 24;
  localparam int unsigned NTAP   = K * K;
  localparam int unsigned WIN_W  = NTAP * PIX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  function automatic logic [PIX_W-1:0] max8(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/simple_cnn_if.sv
// Window feed from the image feeder and class result back to the consumer.
interface simple_cnn_if;
  import cnn_pkg::*;

  logic             START;
  logic [4:0]       X;
  logic [4:0]       Y;
  logic [WIN_W-1:0] IMGIN;
  logic             DONE;
  logic [3:0]       OUT;

  modport master (output START, X, Y, IMGIN, input DONE, OUT);
  modport slave  (input START, X, Y, IMGIN, output DONE, OUT);
endinterface

// File: rtl/cnn_conv5x5.sv
// Combinational 5x5 convolution with bias, ReLU, right shift and 8-bit saturation.
module cnn_conv5x5
  import cnn_pkg::*;
#(
  parameter int unsigned CONV_SHIFT = 4
) (
  input  logic [WIN_W-1:0]        imgin,
  input  logic signed [W_W-1:0]   weights [NTAP+1],
  output logic [PIX_W-1:0]        act
);

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] shifted;

  always_comb begin
    sum = SUM_W'(weights[NTAP]);
    for (int unsigned i = 0; i < NTAP; i++) begin
      sum += SUM_W'(weights[i]) *
             $signed(SUM_W'({1'b0, imgin[8'(WIN_W - 1 - PIX_W * i) -: PIX_W]}));
    end
    shifted = sum >>> CONV_SHIFT;
    if (sum[SUM_W-1])
      act = '0;
    else if (|shifted[SUM_W-1:PIX_W])
      act = '1;
    else
      act = shifted[PIX_W-1:0];
  end

endmodule

// File: rtl/simple_cnn.sv
// Streaming classifier top: window FSM, 2x2 max-pool buffers, FC accumulators, argmax.
module simple_cnn
  import cnn_pkg::*;
#(
  parameter string       CONV_W_FILE = "conv_w.mem",
  parameter string       FC_W_FILE   = "fc_w.mem",
  parameter string       FC_B_FILE   = "fc_b.mem",
  parameter int unsigned CONV_SHIFT  = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  simple_cnn_if.slave bus
);

  logic signed [W_W-1:0] conv_w [NTAP+1];
  logic signed [W_W-1:0] fc_w   [NCLASS*NFEAT];
  logic signed [B_W-1:0] fc_b   [NCLASS];

  state_t state, state_nx;
  logic   win_ok, accept, clear, finish;

  logic [PIX_W-1:0]        act, hold, feat;
  logic [PIX_W-1:0]        colbuf [POOL];
  logic [3:0]              prow, pcol;
  logic [7:0]              fidx;
  logic signed [ACC_W-1:0] acc  [NCLASS];
  logic signed [ACC_W-1:0] prod [NCLASS];
  logic signed [ACC_W:0]   score, best_score;
  logic [3:0]              best, out_q;
  logic                    done_q;

  cnn_conv5x5 #(.CONV_SHIFT(CONV_SHIFT)) u_conv (
    .imgin   (bus.IMGIN),
    .weights (conv_w),
    .act     (act)
  );

  assign win_ok = (bus.X < 5'(CONV)) && (bus.Y < 5'(CONV));
  assign prow   = bus.Y[4:1];
  assign pcol   = bus.X[4:1];
  assign fidx   = 8'(prow) * 8'(POOL) + 8'(pcol);
  assign feat   = max8(max8(colbuf[prow], hold), act);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.START) begin
      state_nx = S_RUN;
    end else begin
      case (state)
        S_IDLE:   state_nx = S_IDLE;
        S_RUN:    if (accept && bus.X == 5'(CONV-1) && bus.Y == 5'(CONV-1))
                    state_nx = S_FINISH;
        S_FINISH: state_nx = S_RUN;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    clear  = bus.START;
    accept = 1'b0;
    finish = 1'b0;
    if (!bus.START) begin
      accept = (state == S_RUN) && win_ok;
      finish = (state == S_FINISH);
    end
  end

  // Even rows park in hold; odd rows fold into the column buffer or emit a feature.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hold <= '0;
      for (int unsigned i = 0; i < POOL; i++) colbuf[i] <= '0;
    end else if (clear) begin
      hold <= '0;
      for (int unsigned i = 0; i < POOL; i++) colbuf[i] <= '0;
    end else if (accept) begin
      if (!bus.Y[0])      hold         <= act;
      else if (!bus.X[0]) colbuf[prow] <= max8(hold, act);
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < NCLASS; j++)
      prod[j] = ACC_W'(fc_w[11'(j * NFEAT) + 11'(fidx)]) *
                $signed(ACC_W'({1'b0, feat}));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned j = 0; j < NCLASS; j++) acc[j] <= '0;
    end else if (clear || finish) begin
      for (int unsigned j = 0; j < NCLASS; j++) acc[j] <= '0;
    end else if (accept && bus.X[0] && bus.Y[0]) begin
      for (int unsigned j = 0; j < NCLASS; j++) acc[j] <= acc[j] + prod[j];
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best       = '0;
    score      = '0;
    best_score = (ACC_W+1)'(acc[0]) + (ACC_W+1)'(fc_b[0]);
    for (int unsigned j = 1; j < NCLASS; j++) begin
      score = (ACC_W+1)'(acc[j]) + (ACC_W+1)'(fc_b[j]);
      if (score > best_score) begin
        best_score = score;
        best       = 4'(j);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      done_q <= 1'b0;
      out_q  <= '0;
    end else if (clear) begin
      done_q <= 1'b0;
    end else if (finish) begin
      done_q <= 1'b1;
      out_q  <= best;
    end else if (accept) begin
      done_q <= 1'b0;
    end
  end

  assign bus.DONE = done_q;
  assign bus.OUT  = out_q;

endmodule

// File: tb/tb_simple_cnn.sv
// Self-checking bench for simple_cnn: table of weight/image setups plus reset and back-to-back sequences.
module tb_simple_cnn;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic nrst;

  simple_cnn_if bus ();

  simple_cnn #(
    .CONV_W_FILE (""),
    .FC_W_FILE   (""),
    .FC_B_FILE   (""),
    .CONV_SHIFT  (4)
  ) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]        conv_mode;  // 0 zero, 1 centre 16, 2 centre 16 bias -1, 3 random
    logic [1:0]        fc_mode;    // 0 zero, 1 row 3 all ones, 2 random
    logic              img_kind;   // 0 constant, 1 ramp pattern
    logic [7:0]        img_val;
    logic [9:0][15:0]  fcb;
    logic [4:0]        exp_out;
  } vec_t;

  localparam int USE_MODEL = 31;
  localparam int NVEC      = 10;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cw  [26];
  int   fw  [1440];
  int   fb  [10];
  int   img [28][28];
  int   exp_q [$];
  bit   done_prev = 1'b0;
  vec_t vecs [NVEC];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int conv, input int fc, input int kind, input int val,
                              input int bidx, input int bval, input int ex);
    vec_t v;
    v.conv_mode = 2'(conv);
    v.fc_mode   = 2'(fc);
    v.img_kind  = 1'(kind);
    v.img_val   = 8'(val);
    v.fcb       = '0;
    for (int j = 0; j < 10; j++)
      if (bidx == 10 || bidx == j) v.fcb[j] = 16'(bval);
    v.exp_out   = 5'(ex);
    return v;
  endfunction

  task automatic load_weights(input vec_t v);
    for (int i = 0; i < 26; i++) begin
      cw[i] = 0;
      if ((v.conv_mode == 2'd1 || v.conv_mode == 2'd2) && i == 12) cw[i] = 16;
      if (v.conv_mode == 2'd2 && i == 25) cw[i] = -1;
      if (v.conv_mode == 2'd3)
        cw[i] = (i < 25) ? int'($urandom_range(24)) - 12 : int'($urandom_range(255)) - 128;
      dut.conv_w[i] = 8'(cw[i]);
    end
    for (int i = 0; i < 1440; i++) begin
      fw[i] = 0;
      if (v.fc_mode == 2'd1 && i / 144 == 3) fw[i] = 1;
      if (v.fc_mode == 2'd2) fw[i] = int'($urandom_range(255)) - 128;
      dut.fc_w[i] = 8'(fw[i]);
    end
    for (int j = 0; j < 10; j++) begin
      fb[j] = int'($signed(v.fcb[j]));
      dut.fc_b[j] = v.fcb[j];
    end
  endtask

  task automatic set_image(input int kind, input int val);
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        img[r][c] = (kind != 0) ? (r * 37 + c * 11 + val) % 256 : val;
  endtask

  // Reference: whole feature map first, then pool, then dense layer.
  function automatic int model_out();
    int a [24][24];
    int acc [10];
    int s, m, best, bs, sc;
    for (int y = 0; y < 24; y++)
      for (int x = 0; x < 24; x++) begin
        s = cw[25];
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++)
            s += cw[r * 5 + c] * img[y + r][x + c];
        a[y][x] = (s < 0) ? 0 : (((s >>> 4) > 255) ? 255 : (s >>> 4));
      end
    for (int j = 0; j < 10; j++) acc[j] = 0;
    for (int py = 0; py < 12; py++)
      for (int px = 0; px < 12; px++) begin
        m = a[2*py][2*px];
        if (a[2*py+1][2*px]   > m) m = a[2*py+1][2*px];
        if (a[2*py][2*px+1]   > m) m = a[2*py][2*px+1];
        if (a[2*py+1][2*px+1] > m) m = a[2*py+1][2*px+1];
        for (int j = 0; j < 10; j++) acc[j] += fw[j * 144 + py * 12 + px] * m;
      end
    best = 0;
    bs   = acc[0] + fb[0];
    for (int j = 1; j < 10; j++) begin
      sc = acc[j] + fb[j];
      if (sc > bs) begin
        bs   = sc;
        best = j;
      end
    end
    return best;
  endfunction

  task automatic drive_win(input int x, input int y);
    logic [199:0] w;
    w = '0;
    if (x < 24 && y < 24)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          w[199 - 8 * (5 * r + c) -: 8] = 8'(img[y + r][x + c]);
    bus.X     = 5'(x);
    bus.Y     = 5'(y);
    bus.IMGIN = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The window presented alongside START is (23,23); it must not be taken.
  task automatic do_start();
    tick();
    bus.START = 1'b1;
    drive_win(23, 23);
    tick();
    bus.START = 1'b0;
    drive_win(24, 24);
    @(negedge clk);
    check("done_clr_start", int'(bus.DONE), 0);
  endtask

  task automatic run_image(input int n_win, input int exp, input bit push);
    if (push) exp_q.push_back(exp);
    for (int k = 0; k < n_win; k++) begin
      tick();
      drive_win(k / 24, k % 24);
      if (k == 1) begin
        @(negedge clk);
        check("done_drop", int'(bus.DONE), 0);
      end
    end
    if (n_win == 576) begin
      tick();
      drive_win(24, 24);
      @(negedge clk);
      check("done_early", int'(bus.DONE), 0);
      tick();
      @(negedge clk);
      check("done_late", int'(bus.DONE), 1);
    end
  endtask

  always @(negedge clk) begin
    if (bus.DONE && !done_prev) begin
      check("sb_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("sb_out", int'(bus.OUT), exp_q.pop_front());
    end
    done_prev = bus.DONE;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int e;
    vecs[0] = mk(0, 0, 1, 9,   7,  100,   7);
    vecs[1] = mk(0, 0, 1, 9,   10, 50,    0);
    vecs[2] = mk(1, 1, 0, 200, 0,  0,     3);
    vecs[3] = mk(1, 1, 0, 200, 4,  28800, 3);
    vecs[4] = mk(1, 1, 0, 200, 4,  28801, 4);
    vecs[5] = mk(1, 1, 0, 0,   5,  1,     5);
    vecs[6] = mk(2, 1, 0, 0,   5,  1,     5);
    vecs[7] = mk(2, 1, 0, 200, 4,  28657, 4);
    vecs[8] = mk(3, 2, 1, 3,   0,  0,     USE_MODEL);
    vecs[9] = mk(3, 2, 1, 77,  0,  0,     USE_MODEL);

    nrst      = 1'b1;
    bus.START = 1'b0;
    drive_win(24, 24);
    #2 nrst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", int'(bus.DONE), 0);
    check("rst_out", int'(bus.OUT), 0);
    tick();
    nrst = 1'b1;

    set_image(0, 50);
    tick();
    drive_win(23, 23);
    tick();
    drive_win(24, 24);
    @(negedge clk);
    check("idle_ignore", int'(bus.DONE), 0);

    for (int i = 0; i < NVEC; i++) begin
      load_weights(vecs[i]);
      set_image(int'(vecs[i].img_kind), int'(vecs[i].img_val));
      e = (int'(vecs[i].exp_out) == USE_MODEL) ? model_out() : int'(vecs[i].exp_out);
      do_start();
      run_image(576, e, 1'b1);
    end

    // Back to back: image A (all 200) then image B (all 0), two idle windows between.
    load_weights(mk(1, 1, 0, 200, 4, 28000, 3));
    do_start();
    set_image(0, 200);
    run_image(576, 3, 1'b1);
    set_image(0, 0);
    run_image(576, 4, 1'b1);

    // Reset during window 300 aborts; a fresh START reproduces the clean result.
    set_image(0, 200);
    run_image(300, 0, 1'b0);
    tick();
    nrst = 1'b0;
    @(negedge clk);
    check("rst_mid_done", int'(bus.DONE), 0);
    check("rst_mid_out", int'(bus.OUT), 0);
    tick();
    tick();
    nrst = 1'b1;
    do_start();
    run_image(576, 3, 1'b1);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
